vga_timing_gen: RTL

//  Upstream raster stage for the maze renderers. Generates 640x480@60 VGA timing on clk_vga
//  (25 MHz) and drives CurrentX/CurrentY into the map-colour stage. That stage registers its colour.

---
 rtl/vga_timing_pkg.sv | 25 ++
 rtl/vga_timing_gen_sync_delay_line.sv | 36 +++
 rtl/vga_timing_gen.sv | 108 ++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared 640x480@60 raster constants plus a small range helper used by the
// timing generator and the map-colour stages.
package vga_timing_pkg;

  localparam int H_ACTIVE = 640;
  localparam int H_FP     = 16;
  localparam int H_SYNC   = 96;
  localparam int H_BP     = 48;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 480;
  localparam int V_FP     = 10;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 33;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [7:0] FLOOR_GREY = 8'b10110110;

  function automatic logic in_window(input logic [9:0] cnt,
                                     input logic [9:0] lo,
                                     input logic [9:0] hi);
    return (cnt >= lo) && (cnt <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_sync_delay_line.sv
// Fixed-latency shift register that keeps sync/blank aligned with the registered
// colour path; DEPTH=0 degenerates to a wire.
module sync_delay_line #(
  parameter int               WIDTH   = 3,
  parameter int               DEPTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_bypass
      logic unused_s;
      assign unused_s = clk ^ rst;
      assign dout     = din;
    end else begin : g_pipe
      logic [WIDTH-1:0] stage_r [DEPTH];

      // Shift toward the output; reset fills every stage with the idle pattern
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int i = 0; i < DEPTH; i++) stage_r[i] <= RST_VAL;
        end else begin
          stage_r[0] <= din;
          for (int i = 1; i < DEPTH; i++) stage_r[i] <= stage_r[i-1];
        end
      end

      assign dout = stage_r[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing: free-running h/v counters, a stage-0 register of pixel
// coordinates and raw syncs, and a delay line matching the colour-path latency.
module vga_timing_gen #(
  parameter int   H_ACTIVE = vga_timing_pkg::H_ACTIVE,
  parameter int   H_FP     = vga_timing_pkg::H_FP,
  parameter int   H_SYNC   = vga_timing_pkg::H_SYNC,
  parameter int   H_BP     = vga_timing_pkg::H_BP,
  parameter int   V_ACTIVE = vga_timing_pkg::V_ACTIVE,
  parameter int   V_FP     = vga_timing_pkg::V_FP,
  parameter int   V_SYNC   = vga_timing_pkg::V_SYNC,
  parameter int   V_BP     = vga_timing_pkg::V_BP,
  parameter int   PIPE_DLY = 1,
  parameter logic SYNC_POL = 1'b0
) (
  input  logic       clk_vga,
  input  logic       rst,
  output logic [9:0] CurrentX,
  output logic [8:0] CurrentY,
  output logic       active,
  output logic       hsync,
  output logic       vsync,
  output logic       blank_n,
  output logic       vblank_start
);
  import vga_timing_pkg::*;

  localparam logic [9:0] H_ACT  = 10'(H_ACTIVE);
  localparam logic [9:0] H_LAST = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] HS_LO  = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HS_HI  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [9:0] V_ACT  = 10'(V_ACTIVE);
  localparam logic [9:0] V_LAST = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] VS_LO  = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VS_HI  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [9:0] h_cnt_r;
  logic [9:0] v_cnt_r;
  logic [9:0] h_nxt_s;
  logic [9:0] v_nxt_s;
  logic       active_nxt_s;
  logic [9:0] cur_x_r;
  logic [8:0] cur_y_r;
  logic       active_r;
  logic       vblank_start_r;
  logic       hs_raw_r;
  logic       vs_raw_r;
  logic [2:0] sync_dly_s;

  // Next raster position; v advances only when h wraps
  always_comb begin
    h_nxt_s = h_cnt_r;
    v_nxt_s = v_cnt_r;
    if (h_cnt_r == H_LAST) begin
      h_nxt_s = 10'd0;
      if (v_cnt_r == V_LAST) begin
        v_nxt_s = 10'd0;
      end else begin
        v_nxt_s = v_cnt_r + 10'd1;
      end
    end else begin
      h_nxt_s = h_cnt_r + 10'd1;
    end
    active_nxt_s = (h_nxt_s < H_ACT) && (v_nxt_s < V_ACT);
  end

  // Counters and stage 0 are loaded from the same next-state values so they move together
  always_ff @(posedge clk_vga) begin
    if (rst) begin
      h_cnt_r        <= 10'd0;
      v_cnt_r        <= 10'd0;
      cur_x_r        <= 10'd0;
      cur_y_r        <= 9'd0;
      active_r       <= 1'b1;
      vblank_start_r <= 1'b0;
      hs_raw_r       <= ~SYNC_POL;
      vs_raw_r       <= ~SYNC_POL;
    end else begin
      h_cnt_r        <= h_nxt_s;
      v_cnt_r        <= v_nxt_s;
      active_r       <= active_nxt_s;
      cur_x_r        <= active_nxt_s ? h_nxt_s : 10'd0;
      cur_y_r        <= active_nxt_s ? v_nxt_s[8:0] : 9'd0;
      vblank_start_r <= (h_nxt_s == 10'd0) && (v_nxt_s == V_ACT);
      hs_raw_r       <= in_window(h_nxt_s, HS_LO, HS_HI) ? SYNC_POL : ~SYNC_POL;
      vs_raw_r       <= in_window(v_nxt_s, VS_LO, VS_HI) ? SYNC_POL : ~SYNC_POL;
    end
  end

  sync_delay_line #(
    .WIDTH   (3),
    .DEPTH   (PIPE_DLY),
    .RST_VAL ({~SYNC_POL, ~SYNC_POL, 1'b0})
  ) u_sync_dly (
    .clk  (clk_vga),
    .rst  (rst),
    .din  ({hs_raw_r, vs_raw_r, active_r}),
    .dout (sync_dly_s)
  );

  assign CurrentX     = cur_x_r;
  assign CurrentY     = cur_y_r;
  assign active       = active_r;
  assign vblank_start = vblank_start_r;
  assign hsync        = sync_dly_s[2];
  assign vsync        = sync_dly_s[1];
  assign blank_n      = sync_dly_s[0];

endmodule
